fpu_issue_arbiter: RTL and testbench

Sequences the FP add/sub pipeline's input stage and shares it between two requesters: requester 0 is the host/interface path and requester 1 is the iterative unit. The block grants one requester at a time round-robin and latches its operands. It drives the pipeline's start/operand inputs for the fixed issue window the input-enable FSM expects. It tracks in-flight operations by tag so each returned result is routed to the requester that issued it.

---
 rtl/fpu_ctrl_pkg.sv | 29 ++
 rtl/fpu_issue_arbiter_if.sv | 55 +++++
 rtl/fpu_tag_fifo.sv | 74 +++++++
 rtl/fpu_issue_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_ctrl_pkg
// Purpose  : Shared encodings for the FP add/sub issue arbiter: arbiter FSM
//            states, requester IDs, opcode values and a small one-hot helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_ITER = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Requester ID to its bit in the 2-bit gnt/res_valid vectors.
  function automatic logic [1:0] req_onehot(input logic id);
    return (id == REQ_ITER) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_arbiter_if
// Purpose  : Bundles the requester handshake, the pipeline issue/return bus
//            and the arbiter status outputs.
// Ports    : slave modport  - arbiter side (fpu_issue_arbiter)
//            master modport - requesters + pipeline side
//            req/a0/b0/sub0/a1/b1/sub1 -> gnt
//            pipe_init/pipe_a/pipe_b/pipe_sub  (to pipeline)
//            pipe_res_valid/pipe_res           (from pipeline)
//            res_valid/res, busy/inflight/err_underflow
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_issue_arbiter_if #(
  parameter int W            = 32,
  parameter int MAX_INFLIGHT = 4
);
  localparam int INF_W = $clog2(MAX_INFLIGHT) + 1;

  logic [1:0]       req;
  logic [W-1:0]     a0;
  logic [W-1:0]     b0;
  logic             sub0;
  logic [W-1:0]     a1;
  logic [W-1:0]     b1;
  logic             sub1;
  logic [1:0]       gnt;

  logic             pipe_init;
  logic [W-1:0]     pipe_a;
  logic [W-1:0]     pipe_b;
  logic             pipe_sub;
  logic             pipe_res_valid;
  logic [W-1:0]     pipe_res;

  logic [1:0]       res_valid;
  logic [W-1:0]     res;
  logic             busy;
  logic [INF_W-1:0] inflight;
  logic             err_underflow;

  modport slave (
    input  req, a0, b0, sub0, a1, b1, sub1, pipe_res_valid, pipe_res,
    output gnt, pipe_init, pipe_a, pipe_b, pipe_sub,
    output res_valid, res, busy, inflight, err_underflow
  );

  modport master (
    output req, a0, b0, sub0, a1, b1, sub1, pipe_res_valid, pipe_res,
    input  gnt, pipe_init, pipe_a, pipe_b, pipe_sub,
    input  res_valid, res, busy, inflight, err_underflow
  );

endinterface
`default_nettype wire

// File: rtl/fpu_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fpu_tag_fifo
// Purpose  : DEPTH-entry, 1-bit-wide synchronous FIFO holding the requester
//            ID of every issued-but-unreturned operation, oldest at the head.
// Ports    : clk, rst_n       - clock, async active-low reset
//            push, din        - enqueue din (ignored when full)
//            pop, dout        - dequeue head (ignored when empty); dout is
//                               the current head, valid when !empty
//            count            - occupancy 0..DEPTH
//            empty, full      - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module fpu_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic                     din,
  output logic                          dout,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          empty,
  output logic                          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      // A simultaneous push and pop moves both pointers but leaves the count.
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_arbiter
// Purpose  : Shares the FP add/sub pipeline input stage between the host path
//            (requester 0) and the iterative unit (requester 1). Grants one
//            requester at a time round-robin, latches its operands, holds
//            pipe_init for HOLD_CYCLES of every ISSUE_CYCLES-long issue
//            period, and routes each returned result back to its issuer
//            using an in-order tag FIFO.
// Ports    : clk, rst_n - clock, async active-low reset
//            bus        - fpu_issue_arbiter_if.slave (requests/grants,
//                         pipeline issue and return, result and status)
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_arbiter
  import fpu_ctrl_pkg::*;
#(
  parameter int W            = 32,
  parameter int ISSUE_CYCLES = 6,
  parameter int HOLD_CYCLES  = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  fpu_issue_arbiter_if.slave  bus
);

  localparam int PH_W  = $clog2(ISSUE_CYCLES);
  localparam int INF_W = $clog2(MAX_INFLIGHT) + 1;

  localparam logic [PH_W-1:0] PH_HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_ISSUE_LAST = PH_W'(ISSUE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [PH_W-1:0]  phase;        // cycles since the grant, minus one
  logic             rr_ptr;       // requester that wins a tie

  logic             grant_window;
  logic             can_accept;
  logic             grant;
  logic             winner;

  logic [W-1:0]     issue_a;
  logic [W-1:0]     issue_b;
  logic             issue_sub;

  logic [1:0]       res_valid_q;
  logic [W-1:0]     res_q;
  logic             err_q;

  logic [INF_W-1:0] tag_count;
  logic             tag_out;
  logic             tag_empty;
  logic             tag_full;

  // --------------------------------------------------------------------------
  // Grant decision: only in IDLE or the final GAP cycle, against the
  // registered occupancy (a same-cycle result does not open a slot).
  // rst_n is folded in so gnt stays low while reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_window = (state == IDLE) || ((state == GAP) && (phase == PH_ISSUE_LAST));
    can_accept   = (tag_count < INF_W'(MAX_INFLIGHT));
    grant        = rst_n && grant_window && (|bus.req) && can_accept;

    if (bus.req[0] && bus.req[1]) begin
      winner = rr_ptr;
    end else if (bus.req[1]) begin
      winner = REQ_ITER;
    end else begin
      winner = REQ_HOST;
    end
  end

  // --------------------------------------------------------------------------
  // Arbiter FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (phase == PH_HOLD_LAST) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (phase == PH_ISSUE_LAST) begin
          state_nxt = grant ? ISSUE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase restarts at zero on the first ISSUE cycle after each grant, so the
  // whole period is tracked by one counter spanning ISSUE and GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (grant || (state == IDLE)) begin
      phase <= '0;
    end else begin
      phase <= phase + PH_W'(1);
    end
  end

  // Round-robin pointer and issue registers update only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= REQ_HOST;
      issue_a   <= '0;
      issue_b   <= '0;
      issue_sub <= OP_ADD;
    end else if (grant) begin
      rr_ptr    <= ~winner;
      issue_a   <= (winner == REQ_ITER) ? bus.a1   : bus.a0;
      issue_b   <= (winner == REQ_ITER) ? bus.b1   : bus.b0;
      issue_sub <= (winner == REQ_ITER) ? bus.sub1 : bus.sub0;
    end
  end

  // --------------------------------------------------------------------------
  // In-flight tag tracking and result routing
  // --------------------------------------------------------------------------
  fpu_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .pop   (bus.pipe_res_valid),
    .din   (winner),
    .dout  (tag_out),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  // A result with no outstanding tag is dropped and flagged; res keeps its
  // previous value in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= '0;
      if (bus.pipe_res_valid) begin
        if (tag_empty) begin
          err_q <= 1'b1;
        end else begin
          res_q       <= bus.pipe_res;
          res_valid_q <= req_onehot(tag_out);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.gnt           = grant ? req_onehot(winner) : 2'b00;
  assign bus.pipe_init     = (state == ISSUE);
  assign bus.pipe_a        = issue_a;
  assign bus.pipe_b        = issue_b;
  assign bus.pipe_sub      = issue_sub;
  assign bus.res_valid     = res_valid_q;
  assign bus.res           = res_q;
  assign bus.busy          = (state != IDLE) || (tag_count != '0) || tag_full;
  assign bus.inflight      = tag_count;
  assign bus.err_underflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_arbiter
// Purpose  : Self-checking bench for fpu_issue_arbiter. A reference queue of
//            issued requester IDs predicts result routing; expected results
//            are queued when a pipeline result is driven and compared when
//            res_valid is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_arbiter;
  import fpu_ctrl_pkg::*;

  localparam int W     = 32;
  localparam int ISSUE = 6;
  localparam int HOLD  = 3;
  localparam int MAXI  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_issue_arbiter_if #(.W(W), .MAX_INFLIGHT(MAXI)) bus ();

  fpu_issue_arbiter #(
    .W            (W),
    .ISSUE_CYCLES (ISSUE),
    .HOLD_CYCLES  (HOLD),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic         valid;
    logic         tag;
    logic [W-1:0] val;
  } exp_t;

  int     errors = 0;
  int     checks = 0;
  logic   tag_q[$];     // reference model of outstanding issuer IDs
  exp_t   exp_q[$];     // scoreboard of pending result expectations
  logic   rr_fav;       // requester the model expects to win a tie
  int     exp_inf;
  logic   exp_err;

  task automatic clear_inputs();
    bus.req = 2'b00;
    bus.a0 = '0; bus.b0 = '0; bus.sub0 = 1'b0;
    bus.a1 = '0; bus.b1 = '0; bus.sub1 = 1'b0;
    bus.pipe_res_valid = 1'b0;
    bus.pipe_res = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tag_q.delete();
    exp_q.delete();
    rr_fav = 1'b0; exp_inf = 0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Single request from 'who'; bounded wait for its grant, then checks the
  // latched operands on the cycle after the grant.
  task automatic issue_one(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
    int waited;
    bit got;
    waited = 0; got = 0;
    if (who) begin bus.a1 = a; bus.b1 = b; bus.sub1 = s; end
    else     begin bus.a0 = a; bus.b0 = b; bus.sub0 = s; end
    bus.req = req_onehot(who);
    while (!got && waited < 20) begin
      @(negedge clk);
      if (bus.gnt !== 2'b00) got = 1;
      else begin @(posedge clk); #1; waited++; end
    end
    checks++;
    if (!got || bus.gnt !== req_onehot(who)) begin
      errors++;
      $display("FAIL issue_gnt: got %b want %b (waited %0d)", bus.gnt, req_onehot(who), waited);
    end
    if (got) begin
      tag_q.push_back(who);
      rr_fav = ~who;
      exp_inf++;
    end
    @(posedge clk); #1;
    bus.req = 2'b00;
    @(negedge clk);
    checks++;
    if ({bus.pipe_a, bus.pipe_b, bus.pipe_sub} !== {a, b, s}) begin
      errors++;
      $display("FAIL issue_operands: got %h/%h/%b want %h/%h/%b",
               bus.pipe_a, bus.pipe_b, bus.pipe_sub, a, b, s);
    end
    @(posedge clk); #1;
  endtask

  // Drive one pipeline result; must only be used when no grant can coincide.
  task automatic return_result(input logic [W-1:0] val);
    exp_t e;
    logic [1:0] want_rv;
    bus.pipe_res_valid = 1'b1;
    bus.pipe_res = val;
    if (tag_q.size() > 0) begin
      e.valid = 1'b1; e.tag = tag_q.pop_front(); e.val = val; exp_inf--;
    end else begin
      e.valid = 1'b0; e.tag = 1'b0; e.val = '0; exp_err = 1'b1;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.pipe_res_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    want_rv = e.valid ? req_onehot(e.tag) : 2'b00;
    checks++;
    if (bus.res_valid !== want_rv) begin
      errors++;
      $display("FAIL res_valid: got %b want %b", bus.res_valid, want_rv);
    end
    if (e.valid) begin
      checks++;
      if (bus.res !== e.val) begin
        errors++;
        $display("FAIL res_value: got %h want %h", bus.res, e.val);
      end
    end
    checks++;
    if (bus.err_underflow !== exp_err) begin
      errors++;
      $display("FAIL err_underflow: got %b want %b", bus.err_underflow, exp_err);
    end
    checks++;
    if (bus.inflight !== 3'(exp_inf)) begin
      errors++;
      $display("FAIL inflight_after_ret: got %0d want %0d", bus.inflight, exp_inf);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.res_valid !== 2'b00) begin
      errors++;
      $display("FAIL res_valid_pulse: got %b want 00", bus.res_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.gnt, bus.pipe_init, bus.res_valid, bus.busy, bus.inflight, bus.err_underflow} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0",
               {bus.gnt, bus.pipe_init, bus.res_valid, bus.busy, bus.inflight, bus.err_underflow});
    end
    checks++;
    if ({bus.pipe_a, bus.pipe_b, bus.pipe_sub, bus.res} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%b/%h want 0", bus.pipe_a, bus.pipe_b, bus.pipe_sub, bus.res);
    end
    do_reset();
    checks++;
    if ({bus.busy, bus.pipe_init, bus.inflight} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b want 0", {bus.busy, bus.pipe_init, bus.inflight});
    end
  endtask

  task automatic test_single();
    logic exp_init;
    bus.a0 = 32'h3F80_0000; bus.b0 = 32'h4000_0000; bus.sub0 = OP_ADD;
    bus.req = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL single_gnt: got %b want 01", bus.gnt);
    end
    tag_q.push_back(REQ_HOST); rr_fav = 1'b1; exp_inf++;
    @(posedge clk); #1;
    bus.req = 2'b00;
    for (int k = 1; k <= ISSUE; k++) begin
      @(negedge clk);
      exp_init = (k <= HOLD);
      checks++;
      if (bus.pipe_init !== exp_init || bus.gnt !== 2'b00) begin
        errors++;
        $display("FAIL single_window k=%0d: init=%b gnt=%b want init=%b gnt=00", k, bus.pipe_init, bus.gnt, exp_init);
      end
      if (k == 1) begin
        checks++;
        if ({bus.pipe_a, bus.pipe_b, bus.pipe_sub} !== {32'h3F80_0000, 32'h4000_0000, OP_ADD}) begin
          errors++;
          $display("FAIL single_operands: got %h/%h/%b", bus.pipe_a, bus.pipe_b, bus.pipe_sub);
        end
      end
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    return_result(32'h4040_0000);
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg;
    logic       ei;
    logic       last_win;
    do_reset();
    bus.a0 = 32'hA000_0000; bus.b0 = 32'hB000_0000; bus.sub0 = OP_ADD;
    bus.a1 = 32'hA111_1111; bus.b1 = 32'hB111_1111; bus.sub1 = OP_SUB;
    bus.req = 2'b11;
    last_win = 1'b0;
    for (int c = 0; c <= 3 * ISSUE; c++) begin
      @(negedge clk);
      eg = ((c % ISSUE == 0) && (c / ISSUE < 3)) ? req_onehot(rr_fav) : 2'b00;
      ei = (c > 0) && (((c - 1) % ISSUE) < HOLD) && (((c - 1) / ISSUE) < 3);
      checks++;
      if (bus.gnt !== eg || bus.pipe_init !== ei) begin
        errors++;
        $display("FAIL b2b c=%0d: gnt=%b init=%b want gnt=%b init=%b", c, bus.gnt, bus.pipe_init, eg, ei);
      end
      checks++;
      if (bus.inflight !== 3'(exp_inf)) begin
        errors++;
        $display("FAIL b2b_inflight c=%0d: got %0d want %0d", c, bus.inflight, exp_inf);
      end
      if (c % ISSUE == 1 && c / ISSUE < 3) begin
        checks++;
        if ({bus.pipe_a, bus.pipe_sub} !== (last_win ? {32'hA111_1111, OP_SUB} : {32'hA000_0000, OP_ADD})) begin
          errors++;
          $display("FAIL b2b_operands c=%0d: got %h/%b for requester %b", c, bus.pipe_a, bus.pipe_sub, last_win);
        end
      end
      if (eg != 2'b00) begin
        last_win = rr_fav;
        tag_q.push_back(rr_fav);
        rr_fav = ~rr_fav;
        exp_inf++;
      end
      @(posedge clk); #1;
      if (c == 2 * ISSUE) bus.req = 2'b00;
    end
  endtask

  task automatic test_interleaved();
    return_result(32'h1111_1111);
    repeat (2) begin @(posedge clk); #1; end
    return_result(32'h2222_2222);
    @(posedge clk); #1;
    return_result(32'h3333_3333);
    checks++;
    if (bus.busy !== 1'b0 || bus.inflight !== 3'd0) begin
      errors++;
      $display("FAIL interleaved_drain: busy=%b inflight=%0d want 0/0", bus.busy, bus.inflight);
    end
  endtask

  task automatic test_capacity();
    exp_t e;
    do_reset();
    issue_one(1'b0, 32'hC000_0001, 32'hD000_0001, OP_ADD);
    issue_one(1'b1, 32'hC000_0002, 32'hD000_0002, OP_SUB);
    issue_one(1'b0, 32'hC000_0003, 32'hD000_0003, OP_SUB);
    issue_one(1'b1, 32'hC000_0004, 32'hD000_0004, OP_ADD);
    repeat (ISSUE) begin @(posedge clk); #1; end
    bus.a0 = 32'hCAFE_0005; bus.b0 = 32'hD000_0005; bus.sub0 = OP_ADD;
    bus.req = 2'b01;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 2'b00 || bus.pipe_init !== 1'b0 || bus.inflight !== 3'd4) begin
        errors++;
        $display("FAIL cap_block k=%0d: gnt=%b init=%b inflight=%0d", k, bus.gnt, bus.pipe_init, bus.inflight);
      end
      @(posedge clk); #1;
    end
    bus.pipe_res_valid = 1'b1; bus.pipe_res = 32'h5555_0001;
    e.valid = 1'b1; e.tag = tag_q.pop_front(); e.val = 32'h5555_0001; exp_inf--;
    exp_q.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b00) begin
      errors++;
      $display("FAIL cap_no_bypass: got %b want 00", bus.gnt);
    end
    @(posedge clk); #1;
    bus.pipe_res_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.inflight !== 3'(exp_inf) || bus.gnt !== 2'b01) begin
      errors++;
      $display("FAIL cap_regrant: inflight=%0d gnt=%b want %0d/01", bus.inflight, bus.gnt, exp_inf);
    end
    checks++;
    if (bus.res_valid !== req_onehot(e.tag) || bus.res !== e.val) begin
      errors++;
      $display("FAIL cap_result: rv=%b res=%h want %b/%h", bus.res_valid, bus.res, req_onehot(e.tag), e.val);
    end
    tag_q.push_back(REQ_HOST); rr_fav = 1'b1; exp_inf++;
    @(posedge clk); #1;
    bus.req = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.inflight !== 3'(exp_inf) || bus.pipe_a !== 32'hCAFE_0005 || bus.pipe_init !== 1'b1) begin
      errors++;
      $display("FAIL cap_issue: inflight=%0d a=%h init=%b want %0d/cafe0005/1", bus.inflight, bus.pipe_a, bus.pipe_init, exp_inf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    exp_t e;
    do_reset();
    issue_one(1'b1, 32'h1234_0001, 32'h5678_0001, OP_SUB);
    repeat (ISSUE) begin @(posedge clk); #1; end
    bus.a0 = 32'h0BAD_0002; bus.b0 = 32'h0BEE_0002; bus.sub0 = OP_ADD;
    bus.req = 2'b01;
    bus.pipe_res_valid = 1'b1; bus.pipe_res = 32'h7777_0001;
    e.valid = 1'b1; e.tag = tag_q.pop_front(); e.val = 32'h7777_0001;
    exp_q.push_back(e);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b01 || bus.inflight !== 3'd1) begin
      errors++;
      $display("FAIL simul_gnt: gnt=%b inflight=%0d want 01/1", bus.gnt, bus.inflight);
    end
    tag_q.push_back(REQ_HOST); rr_fav = 1'b1;
    @(posedge clk); #1;
    bus.req = 2'b00; bus.pipe_res_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.inflight !== 3'd1) begin
      errors++;
      $display("FAIL simul_inflight: got %0d want 1", bus.inflight);
    end
    checks++;
    if (bus.res_valid !== req_onehot(e.tag) || bus.res !== e.val || bus.pipe_a !== 32'h0BAD_0002) begin
      errors++;
      $display("FAIL simul_route: rv=%b res=%h a=%h want %b/%h/0bad0002", bus.res_valid, bus.res, bus.pipe_a, req_onehot(e.tag), e.val);
    end
    repeat (ISSUE) begin @(posedge clk); #1; end
    return_result(32'h7777_0002);
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_one(1'b0, 32'h4242_0000, 32'h2424_0000, OP_ADD);
    checks++;
    if (bus.pipe_init !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_init: got %b want 1", bus.pipe_init);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pipe_init !== 1'b0 || bus.inflight !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: init=%b inflight=%0d busy=%b want 0/0/0", bus.pipe_init, bus.inflight, bus.busy);
    end
    tag_q.delete(); exp_inf = 0; rr_fav = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    return_result(32'h9999_0000);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", bus.err_underflow);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_interleaved();
    test_capacity();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
